// File: rtl/bus_arbiter_mux.sv
// Registered bus multiplexer with a round-robin, burst-limited request/grant arbiter.
// One owner per cycle drives its sampled word onto bus_out with a matching one-hot grant.
module bus_arbiter_mux #(
    parameter int WIDTH    = 32,
    parameter int NSRC     = 8,
    parameter int MAXBURST = 4,
    localparam int OW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [NSRC-1:0]       src_req,
    input  logic [NSRC*WIDTH-1:0] src_data,
    output logic [NSRC-1:0]       src_grant,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [OW-1:0]         bus_owner
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_OWN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [3:0]       beats_q, beats_d;
    logic [NSRC-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;

    logic             found;
    logic [OW-1:0]    pick;
    logic             keepOwner;

    // Search starts just past the current owner and wraps through the owner itself,
    // so an exhausted burst with no competitor re-grants the same source seamlessly.
    always_comb begin
        found = 1'b0;
        pick  = owner_q;
        for (int k = 1; k <= NSRC; k++) begin
            int idx;
            idx = (int'(owner_q) + k) % NSRC;
            if (!found && src_req[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    assign keepOwner = (state_q == S_OWN) && src_req[owner_q] && (beats_q < 4'(MAXBURST));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beats_d = beats_q;
        grant_d = '0;
        bus_d   = bus_q;
        valid_d = 1'b0;
        if (keepOwner) begin
            state_d = S_OWN;
            beats_d = beats_q + 4'd1;
        end else if (found) begin
            state_d = S_OWN;
            owner_d = pick;
            beats_d = 4'd1;
        end else begin
            state_d = S_IDLE;
        end
        if (state_d == S_OWN) begin
            bus_d   = src_data[int'(owner_d)*WIDTH +: WIDTH];
            grant_d = NSRC'(1) << owner_d;
            valid_d = 1'b1;
        end
    end

    // Owner resets to the last index so the first post-reset search begins at source 0.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            owner_q <= OW'(NSRC - 1);
            beats_q <= 4'd1;
            grant_q <= '0;
            bus_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
            grant_q <= grant_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
        end
    end

    assign src_grant = grant_q;
    assign bus_out   = bus_q;
    assign bus_valid = valid_q;
    assign bus_owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: NSRC=4, WIDTH=32 with MAXBURST=3 and a MAXBURST=1 twin.
module tb_bus_arbiter_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic           clock;
    logic           clear_n;
    logic [N-1:0]   src_req;
    logic [N*W-1:0] src_data;

    logic [N-1:0]   grantA, grantB;
    logic [W-1:0]   busA, busB;
    logic           validA, validB;
    logic [1:0]     ownerA, ownerB;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [N-1:0] req;
        logic         expValid;
        logic [1:0]   expOwner;
        logic [W-1:0] expBus;
    } vec_t;

    vec_t vecs[$];

    bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .MAXBURST(3)) dutA (
        .clock(clock), .clear_n(clear_n), .src_req(src_req), .src_data(src_data),
        .src_grant(grantA), .bus_out(busA), .bus_valid(validA), .bus_owner(ownerA)
    );

    bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .MAXBURST(1)) dutB (
        .clock(clock), .clear_n(clear_n), .src_req(src_req), .src_data(src_data),
        .src_grant(grantB), .bus_out(busB), .bus_valid(validB), .bus_owner(ownerB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] req);
        src_req = req;
        @(posedge clock);
        #1;
    endtask

    task automatic checkA(input string tag, input logic v, input logic [1:0] o, input logic [W-1:0] b);
        logic [N-1:0] g;
        g = v ? (N'(1) << o) : '0;
        checkOutput({tag, " grant"}, 64'(grantA), 64'(g));
        checkOutput({tag, " valid"}, 64'(validA), 64'(v));
        checkOutput({tag, " owner"}, 64'(ownerA), 64'(o));
        checkOutput({tag, " bus"},   64'(busA),   64'(b));
    endtask

    function automatic void addVec(input logic [N-1:0] r, input logic v, input logic [1:0] o,
                                   input logic [W-1:0] b);
        vec_t x;
        x.req = r; x.expValid = v; x.expOwner = o; x.expBus = b;
        vecs.push_back(x);
    endfunction

    function automatic logic [W-1:0] dw(input int i);
        return 32'h1000_0000 + W'(i);
    endfunction

    initial begin
        // Main sequence table, starting from reset state (IDLE, owner 3).
        for (int i = 0; i < 5; i++) addVec(4'b0100, 1'b1, 2'd2, 32'hA5A5_0002);
        addVec(4'b0000, 1'b0, 2'd2, 32'hA5A5_0002);
        addVec(4'b0000, 1'b0, 2'd2, 32'hA5A5_0002);
        // Data for source 2 switches to 0x1000_0002 at vector index 7 (see loop below).
        begin
            int seq2[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
            for (int i = 0; i < 9; i++) addVec(4'b0011, 1'b1, 2'(seq2[i]), dw(seq2[i]));
        end
        addVec(4'b0000, 1'b0, 2'd0, dw(0));
        addVec(4'b1000, 1'b1, 2'd3, dw(3));
        addVec(4'b0000, 1'b0, 2'd3, dw(3));
        for (int i = 0; i < 3; i++) addVec(4'b1111, 1'b1, 2'd0, dw(0));
        addVec(4'b1111, 1'b1, 2'd1, dw(1));
        begin
            int seq4[7] = '{2, 2, 2, 3, 3, 3, 0};
            for (int i = 0; i < 7; i++) addVec(4'b1101, 1'b1, 2'(seq4[i]), dw(seq4[i]));
        end
        addVec(4'b0000, 1'b0, 2'd0, dw(0));

        // Reset held with random activity on the inputs.
        clear_n  = 1'b0;
        src_req  = '0;
        src_data = '0;
        #2;
        for (int i = 0; i < 4; i++) begin
            src_data = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(4'($urandom));
            checkA("reset", 1'b0, 2'd3, '0);
        end
        src_req  = '0;
        src_data = {dw(3), 32'hA5A5_0002, dw(1), dw(0)};
        clear_n  = 1'b1;
        #1;
        checkA("release", 1'b0, 2'd3, '0);
        applyStimulus(4'b0000);
        checkA("release edge", 1'b0, 2'd3, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 7) src_data[2*W +: W] = dw(2);
            applyStimulus(vecs[i].req);
            checkA($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expOwner, vecs[i].expBus);
        end

        // Reset mid-burst: owner 2 on beat 2, then asynchronous clear between edges.
        applyStimulus(4'b0100);
        applyStimulus(4'b0100);
        checkA("preburst", 1'b1, 2'd2, dw(2));
        #2;
        clear_n = 1'b0;
        #1;
        checkA("async reset", 1'b0, 2'd3, '0);
        #2;
        src_req = 4'b1111;
        clear_n = 1'b1;
        applyStimulus(4'b1111);
        checkA("post reset grant", 1'b1, 2'd0, dw(0));

        // MAXBURST=1 twin rotates every cycle.
        src_req = '0;
        clear_n = 1'b0;
        #2;
        clear_n = 1'b1;
        begin
            int seqB[5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) begin
                applyStimulus(4'b1111);
                checkOutput($sformatf("burst1 owner%0d", i), 64'(ownerB), 64'(seqB[i]));
                checkOutput($sformatf("burst1 grant%0d", i), 64'(grantB), 64'(N'(1) << seqB[i]));
                checkOutput($sformatf("burst1 bus%0d", i),   64'(busB),   64'(dw(seqB[i])));
                checkOutput($sformatf("burst1 valid%0d", i), 64'(validB), 64'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
